// File: rtl/s_axi_lite_mem.sv
// s_axi_lite_mem: AXI4-Lite slave backed by a DEPTH-word register array with
// independent read/write FSMs and saturating traffic/error counters.
module s_axi_lite_mem #(
    parameter int DWIDTH  = 32,
    parameter int DEPTH   = 16,
    parameter int CNT_BIT = 16
) (
    input  logic                  clk,
    input  logic                  xrst,
    input  logic [DWIDTH-1:0]     base,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DWIDTH-1:0]     awaddr,
    input  logic [2:0]            awprot,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DWIDTH-1:0]     wdata,
    input  logic [DWIDTH/8-1:0]   wstrb,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [DWIDTH-1:0]     araddr,
    input  logic [2:0]            arprot,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DWIDTH-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic [CNT_BIT-1:0]    wcnt,
    output logic [CNT_BIT-1:0]    rcnt,
    output logic [CNT_BIT-1:0]    ecnt
);
    localparam int IDX_BIT = $clog2(DEPTH);
    localparam int SB = DWIDTH / 8;
    localparam logic [DWIDTH-1:0] SPAN = DWIDTH'(DEPTH * 4);
    localparam logic [CNT_BIT-1:0] CMAX = '1;

    typedef enum logic {W_ACCEPT, W_RESP} w_state_t;
    typedef enum logic {R_ACCEPT, R_DATA} r_state_t;

    w_state_t w_state;
    r_state_t r_state;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic aw_got, w_got;
    logic [IDX_BIT:0] aw_dec;
    logic [DWIDTH-1:0] w_data;
    logic [SB-1:0] w_strb;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_next, w_next;
    logic [IDX_BIT:0] c_dec, r_dec;
    logic [DWIDTH-1:0] c_data;
    logic [SB-1:0] c_strb;
    logic [1:0] e_add;
    logic [CNT_BIT:0] e_sum;
    logic unused;

    // {in-range-and-aligned, word index}; offset wraps at DWIDTH bits
    function automatic logic [IDX_BIT:0] decode(input logic [DWIDTH-1:0] addr, input logic [DWIDTH-1:0] b);
        logic [DWIDTH-1:0] off;
        off = addr - b;
        return {addr[1:0] == 2'b00 && off < SPAN, off[IDX_BIT+1:2]};
    endfunction

    assign unused = ^{awprot, arprot};
    assign aw_hs = awvalid && awready;
    assign w_hs = wvalid && wready;
    assign ar_hs = arvalid && arready;
    assign b_hs = bvalid && bready;
    assign r_hs = rvalid && rready;
    assign aw_next = aw_got || aw_hs;
    assign w_next = w_got || w_hs;
    // commit may coincide with the last handshake, so take live values then
    assign c_dec = aw_hs ? decode(awaddr, base) : aw_dec;
    assign c_data = w_hs ? wdata : w_data;
    assign c_strb = w_hs ? wstrb : w_strb;
    assign r_dec = decode(araddr, base);
    assign e_add = {1'b0, b_hs && bresp[1]} + {1'b0, r_hs && rresp[1]};
    assign e_sum = {1'b0, ecnt} + (CNT_BIT+1)'(e_add);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            w_state <= W_ACCEPT;
            awready <= 1'b0;
            wready  <= 1'b0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_dec  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (w_state == W_ACCEPT) begin
            if (aw_hs) aw_dec <= decode(awaddr, base);
            if (w_hs) begin
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (aw_next && w_next) begin
                w_state <= W_RESP;
                bvalid  <= 1'b1;
                bresp   <= c_dec[IDX_BIT] ? 2'b00 : 2'b10;
                awready <= 1'b0;
                wready  <= 1'b0;
                aw_got  <= 1'b0;
                w_got   <= 1'b0;
                if (c_dec[IDX_BIT])
                    for (int k = 0; k < SB; k++)
                        if (c_strb[k]) mem[c_dec[IDX_BIT-1:0]][8*k +: 8] <= c_data[8*k +: 8];
            end else begin
                aw_got  <= aw_next;
                w_got   <= w_next;
                awready <= !aw_next;
                wready  <= !w_next;
            end
        end else if (bready) begin
            w_state <= W_ACCEPT;
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state <= R_ACCEPT;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= 2'b00;
        end else if (r_state == R_ACCEPT) begin
            if (ar_hs) begin
                r_state <= R_DATA;
                arready <= 1'b0;
                rvalid  <= 1'b1;
                rdata   <= r_dec[IDX_BIT] ? mem[r_dec[IDX_BIT-1:0]] : '0;
                rresp   <= r_dec[IDX_BIT] ? 2'b00 : 2'b10;
            end else begin
                arready <= 1'b1;
            end
        end else if (rready) begin
            r_state <= R_ACCEPT;
            rvalid  <= 1'b0;
            arready <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            wcnt <= '0;
            rcnt <= '0;
            ecnt <= '0;
        end else begin
            wcnt <= wcnt + CNT_BIT'(b_hs && wcnt != CMAX);
            rcnt <= rcnt + CNT_BIT'(r_hs && rcnt != CMAX);
            ecnt <= e_sum > {1'b0, CMAX} ? CMAX : e_sum[CNT_BIT-1:0];
        end
    end
endmodule
